// File: rtl/neuron_pkg.sv
// Shared types and helpers for the sequential neuron family: FSM state encoding,
// activation-select constants and the accumulator width rule.
package neuron_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_MAC  = 2'd2,
        ST_ACT  = 2'd3
    } state_t;

    localparam bit ACT_RELU   = 1'b1;
    localparam bit ACT_LINEAR = 1'b0;

    // Wide enough to sum N full-width products plus the bias without overflow.
    function automatic int acc_width(input int data_width, input int n_inputs);
        return 2 * data_width + $clog2(n_inputs + 1);
    endfunction

endpackage

// File: rtl/neuron_sat.sv
// Combinational accumulator-to-output resize. Build with NEURON_SAT_EN to clamp
// to the signed output range; otherwise the low bits are kept (two's-complement wrap).
module neuron_sat #(
    parameter int IN_W  = 20,
    parameter int OUT_W = 8
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout
);

`ifdef NEURON_SAT_EN
    localparam logic signed [IN_W-1:0] MAX_V = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [IN_W-1:0] MIN_V = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    always_comb begin
        if (din > MAX_V) begin
            dout = {1'b0, {(OUT_W-1){1'b1}}};
        end else if (din < MIN_V) begin
            dout = {1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            dout = din[OUT_W-1:0];
        end
    end
`else
    logic unused_hi_bits;

    assign dout           = din[OUT_W-1:0];
    assign unused_hi_bits = ^din[IN_W-1:OUT_W];
`endif

endmodule

// File: rtl/neuron_mac_seq.sv
// Sequential neuron: one time-shared multiplier, one MAC per enabled cycle, then
// resize (neuron_sat, NEURON_SAT_EN selects clamp vs wrap) and optional ReLU.
module neuron_mac_seq #(
    parameter int                                DATA_WIDTH = 8,
    parameter int                                FRAC_BITS  = 4,
    parameter int                                N_INPUTS   = 4,
    parameter logic [N_INPUTS*DATA_WIDTH-1:0]    W          = '0,
    parameter logic signed [DATA_WIDTH-1:0]      BIAS       = '0,
    parameter bit                                ACT_RELU   = neuron_pkg::ACT_RELU
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               En,
    input  logic                               Run,
    input  logic [N_INPUTS*DATA_WIDTH-1:0]     X,
    output logic signed [DATA_WIDTH-1:0]       Y,
    output logic                               Busy,
    output logic                               Done
);
    import neuron_pkg::*;

    localparam int ACC_W = acc_width(DATA_WIDTH, N_INPUTS);
    localparam int IDX_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    localparam int PROD_W = 2 * DATA_WIDTH;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_INPUTS - 1);
    localparam logic signed [ACC_W-1:0] BIAS_EXT =
        {{(ACC_W-DATA_WIDTH){BIAS[DATA_WIDTH-1]}}, BIAS};

    state_t                        state;
    logic signed [DATA_WIDTH-1:0]  xr [N_INPUTS];
    logic signed [ACC_W-1:0]       acc;
    logic [IDX_W-1:0]              idx;

    logic signed [DATA_WIDTH-1:0]  x_cur;
    logic signed [DATA_WIDTH-1:0]  w_cur;
    logic signed [PROD_W-1:0]      prod;
    logic signed [PROD_W-1:0]      prod_sh;
    logic signed [ACC_W-1:0]       prod_ext;
    logic signed [DATA_WIDTH-1:0]  r_res;
    logic signed [DATA_WIDTH-1:0]  act_val;

    // Operand select by compare rather than direct index, so idx never reads past the array.
    always_comb begin
        x_cur = '0;
        w_cur = '0;
        for (int i = 0; i < N_INPUTS; i++) begin
            if (idx == IDX_W'(i)) begin
                x_cur = xr[i];
                w_cur = W[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign prod     = x_cur * w_cur;
    assign prod_sh  = prod >>> FRAC_BITS;
    assign prod_ext = {{(ACC_W-PROD_W){prod_sh[PROD_W-1]}}, prod_sh};

    neuron_sat #(
        .IN_W  (ACC_W),
        .OUT_W (DATA_WIDTH)
    ) u_sat (
        .din  (acc),
        .dout (r_res)
    );

    // ReLU is applied after the resize, so a wrapped negative is also forced to zero.
    assign act_val = ((ACT_RELU != ACT_LINEAR) && r_res[DATA_WIDTH-1]) ? '0 : r_res;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            acc   <= '0;
            idx   <= '0;
            Y     <= '0;
            Busy  <= 1'b0;
            Done  <= 1'b0;
            for (int i = 0; i < N_INPUTS; i++) begin
                xr[i] <= '0;
            end
        end else begin
            // Done is a single-cycle pulse even while En is low.
            Done <= 1'b0;
            if (En) begin
                case (state)
                    ST_IDLE: begin
                        if (Run) begin
                            state <= ST_LOAD;
                            Busy  <= 1'b1;
                        end
                    end
                    ST_LOAD: begin
                        for (int i = 0; i < N_INPUTS; i++) begin
                            xr[i] <= X[i*DATA_WIDTH +: DATA_WIDTH];
                        end
                        acc   <= BIAS_EXT;
                        idx   <= '0;
                        state <= ST_MAC;
                    end
                    ST_MAC: begin
                        acc <= acc + prod_ext;
                        if (idx == LAST_IDX) begin
                            idx   <= '0;
                            state <= ST_ACT;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                    ST_ACT: begin
                        Y     <= act_val;
                        Done  <= 1'b1;
                        Busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                    default: begin
                        state <= ST_IDLE;
                        Busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_neuron_mac_seq.sv
// Directed bench for neuron_mac_seq: four parameterisations share one stimulus
// stream; expected results are hand-computed constants.
module tb_neuron_mac_seq;

    localparam int DW = 8;
    localparam int N  = 4;

    localparam logic [N*DW-1:0] W16  = {4{8'd16}};
    localparam logic [N*DW-1:0] W127 = {4{8'd127}};
    localparam logic [N*DW-1:0] W0   = '0;

    localparam logic [N*DW-1:0] X_POS = {8'h08, 8'hF0, 8'h20, 8'h10};  // 8,-16,32,16
    localparam logic [N*DW-1:0] X_NEG = {8'hF8, 8'h10, 8'hE0, 8'hF0};  // -8,16,-32,-16
    localparam logic [N*DW-1:0] X_MAX = {4{8'd127}};
    localparam logic [N*DW-1:0] X_ALT = {8'h7F, 8'h80, 8'h7F, 8'h80};

`ifdef NEURON_SAT_EN
    localparam logic signed [DW-1:0] EXP_BIG = 8'sd127;
`else
    localparam logic signed [DW-1:0] EXP_BIG = -8'sd64;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b1;
    logic run = 1'b0;
    logic [N*DW-1:0] x = '0;

    logic signed [DW-1:0] a_y, b_y, c_y, d_y;
    logic a_busy, b_busy, c_busy, d_busy;
    logic a_done, b_done, c_done, d_done;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    neuron_mac_seq #(.DATA_WIDTH(DW), .FRAC_BITS(4), .N_INPUTS(N), .W(W16),
                     .BIAS(8'sd0), .ACT_RELU(1'b1)) u_a (
        .clk(clk), .rst(rst), .En(en), .Run(run), .X(x),
        .Y(a_y), .Busy(a_busy), .Done(a_done));

    neuron_mac_seq #(.DATA_WIDTH(DW), .FRAC_BITS(4), .N_INPUTS(N), .W(W16),
                     .BIAS(8'sd0), .ACT_RELU(1'b0)) u_b (
        .clk(clk), .rst(rst), .En(en), .Run(run), .X(x),
        .Y(b_y), .Busy(b_busy), .Done(b_done));

    neuron_mac_seq #(.DATA_WIDTH(DW), .FRAC_BITS(4), .N_INPUTS(N), .W(W127),
                     .BIAS(8'sd0), .ACT_RELU(1'b0)) u_c (
        .clk(clk), .rst(rst), .En(en), .Run(run), .X(x),
        .Y(c_y), .Busy(c_busy), .Done(c_done));

    neuron_mac_seq #(.DATA_WIDTH(DW), .FRAC_BITS(4), .N_INPUTS(N), .W(W0),
                     .BIAS(8'sd16), .ACT_RELU(1'b1)) u_d (
        .clk(clk), .rst(rst), .En(en), .Run(run), .X(x),
        .Y(d_y), .Busy(d_busy), .Done(d_done));

    // Driver: assert Run for one cycle from the current negedge.
    task automatic start_run(input logic [N*DW-1:0] xv);
        x   = xv;
        run = 1'b1;
    endtask

    // Driver: count negedges until Done on u_a; lat = -1 if the budget expires.
    task automatic wait_done(output int lat, output int busy_n);
        lat    = -1;
        busy_n = 0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            run = 1'b0;
            if (a_busy) busy_n++;
            if (a_done) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (a_y !== 8'sd0) begin errors++; $display("FAIL reset_y got=%0d exp=0", a_y); end
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", a_busy); end
        checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", a_done); end
        checks++; if (d_y !== 8'sd0) begin errors++; $display("FAIL reset_d_y got=%0d exp=0", d_y); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (b_busy !== 1'b0) begin errors++; $display("FAIL idle_busy got=%b exp=0", b_busy); end
    endtask

    task automatic test_basic();
        int lat, bn;
        start_run(X_POS);
        wait_done(lat, bn);
        checks++; if (lat !== 7) begin errors++; $display("FAIL basic_latency got=%0d exp=7", lat); end
        checks++; if (bn !== 6) begin errors++; $display("FAIL basic_busy_cycles got=%0d exp=6", bn); end
        checks++; if (a_y !== 8'sd40) begin errors++; $display("FAIL basic_relu_y got=%0d exp=40", a_y); end
        checks++; if (b_y !== 8'sd40) begin errors++; $display("FAIL basic_lin_y got=%0d exp=40", b_y); end
        checks++; if (d_y !== 8'sd16) begin errors++; $display("FAIL basic_bias_y got=%0d exp=16", d_y); end
        @(negedge clk);
        checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL done_width got=%b exp=0", a_done); end
        checks++; if (a_y !== 8'sd40) begin errors++; $display("FAIL y_hold got=%0d exp=40", a_y); end
    endtask

    task automatic test_negative();
        int lat, bn;
        start_run(X_NEG);
        wait_done(lat, bn);
        checks++; if (lat !== 7) begin errors++; $display("FAIL neg_latency got=%0d exp=7", lat); end
        checks++; if (a_y !== 8'sd0) begin errors++; $display("FAIL neg_relu_y got=%0d exp=0", a_y); end
        checks++; if (b_y !== -8'sd40) begin errors++; $display("FAIL neg_lin_y got=%0d exp=-40", b_y); end
        checks++; if (d_y !== 8'sd16) begin errors++; $display("FAIL neg_bias_y got=%0d exp=16", d_y); end
        @(negedge clk);
    endtask

    task automatic test_saturation();
        int lat, bn;
        start_run(X_MAX);
        wait_done(lat, bn);
        checks++; if (lat !== 7) begin errors++; $display("FAIL sat_latency got=%0d exp=7", lat); end
        checks++; if (c_y !== EXP_BIG) begin errors++; $display("FAIL sat_y got=%0d exp=%0d", c_y, EXP_BIG); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int lat1, lat2, bn;
        start_run(X_ALT);
        wait_done(lat1, bn);
        checks++; if (d_y !== 8'sd16) begin errors++; $display("FAIL b2b_first_y got=%0d exp=16", d_y); end
        start_run(X_POS);
        wait_done(lat2, bn);
        checks++; if (lat1 !== 7) begin errors++; $display("FAIL b2b_lat1 got=%0d exp=7", lat1); end
        checks++; if (lat2 !== 7) begin errors++; $display("FAIL b2b_lat2 got=%0d exp=7", lat2); end
        checks++; if (d_y !== 8'sd16) begin errors++; $display("FAIL b2b_bias_y got=%0d exp=16", d_y); end
        checks++; if (a_y !== 8'sd40) begin errors++; $display("FAIL b2b_a_y got=%0d exp=40", a_y); end
        @(negedge clk);
    endtask

    task automatic test_enable_stall();
        int lat;
        lat = -1;
        start_run(X_POS);
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            run = 1'b0;
            if (c == 2) x = X_NEG;
            if (c == 3) en = 1'b0;
            if (c == 6) en = 1'b1;
            if (a_done) begin
                lat = c;
                break;
            end
        end
        en = 1'b1;
        checks++; if (lat !== 10) begin errors++; $display("FAIL stall_latency got=%0d exp=10", lat); end
        checks++; if (a_y !== 8'sd40) begin errors++; $display("FAIL stall_a_y got=%0d exp=40", a_y); end
        checks++; if (b_y !== 8'sd40) begin errors++; $display("FAIL stall_b_y got=%0d exp=40", b_y); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        int lat, bn, done_seen;
        done_seen = 0;
        start_run(X_NEG);
        repeat (3) begin
            @(negedge clk);
            run = 1'b0;
        end
        rst = 1'b1;
        #1;
        checks++; if (b_y !== 8'sd0) begin errors++; $display("FAIL rstmid_y got=%0d exp=0", b_y); end
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b exp=0", a_busy); end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (a_done || b_done) done_seen++;
        end
        checks++; if (done_seen !== 0) begin errors++; $display("FAIL rstmid_no_done got=%0d exp=0", done_seen); end
        start_run(X_POS);
        wait_done(lat, bn);
        checks++; if (lat !== 7) begin errors++; $display("FAIL rstmid_latency got=%0d exp=7", lat); end
        checks++; if (b_y !== 8'sd40) begin errors++; $display("FAIL rstmid_y_after got=%0d exp=40", b_y); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_negative();
        test_saturation();
        test_back_to_back();
        test_enable_stall();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
